change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Coin-payout end of the vending coin interface. Takes a change amount in cents from
//  the vending controller and emits a greedy series of coin-eject pulses on N/D/Qtr.
//  Each pulse is one coin, in the same encoding the controller uses for accepted coins.
//  Sits between the controller's change output and the coin-tube solenoid drivers.
// PARAMETERS
//  MAX_CHANGE  35  largest legal change_in, in cents; must be a multiple of 5
//  PULSE_W     4   clk cycles each eject output is held high (1..255)
//  GAP_W       2   clk cycles all eject outputs stay low between coins (1..255)
// PORTS
//  clk        in   1  system clock, rising edge
//  clr        in   1  asynchronous, active-low reset
//  start      in   1  one-cycle request: load change_in and begin payout (ignored while busy)
//  change_in  in   6  change to pay, in cents
//  N          out  1  nickel eject pulse (5c)
//  D          out  1  dime eject pulse (10c)
//  Qtr        out  1  quarter eject pulse (25c)
//  busy       out  1  high from the cycle after an accepted start until the cycle DONE/ERR is left
//  done       out  1  one-cycle pulse: payout complete
//  err        out  1  one-cycle pulse: request rejected or payout impossible
//  remaining  out  6  cents still owed; 0 when idle after success
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE; N=D=Qtr=busy=done=err=0; remaining=0; counters=0.
//  Reset mid-payout: the active pulse drops immediately and the owed amount is discarded.
//  States are IDLE, SELECT, PULSE, GAP, DONE and ERR. At most one of N/D/Qtr is high at any time.
//  IDLE: on start:
//   - change_in==0 -> DONE.
//   - change_in%5!=0 or change_in>MAX_CHANGE -> ERR; remaining is unchanged.
//   - otherwise remaining<=change_in -> SELECT.
//  SELECT (1 cycle, all outputs low):
//   - remaining==0 -> DONE.
//   - else pick a coin greedily: >=25 Qtr, else >=10 D, else N. Latch the coin -> PULSE.
//  PULSE: the latched output is high for exactly PULSE_W cycles.
//   - On the last cycle, remaining <= remaining - coin value (5/10/25). Never underflows.
//   - Then -> GAP.
//  GAP: all outputs low for GAP_W cycles -> SELECT.
//  DONE: done=1 for 1 cycle -> IDLE.  ERR: err=1 for 1 cycle -> IDLE.
//  Latency: start sampled at edge k; first eject output is high from edge k+2.
//  The payout for C cents lasts coins*(PULSE_W+GAP_W+1)+3 cycles, including DONE.
//  A start that arrives while busy (SELECT..ERR) is dropped, with no queueing.
//  A start that arrives in the same cycle as DONE/ERR is also dropped.
//  change_in is sampled only on the accepted start cycle.
// CONFIGURATION
//  DISP_LOW_COIN_EN defined: adds the inputs nickel_empty, dime_empty, qtr_empty (1 bit each,
//   from tube sensors). SELECT skips any empty tube: Qtr if rem>=25 && !qtr_empty,
//   else D if rem>=10 && !dime_empty, else N if !nickel_empty.
//   If no legal coin is left -> ERR, with remaining holding the unpaid amount.
//  DISP_LOW_COIN_EN undefined: the empty ports do not exist and all tubes are treated as full.
// TESTING
//  start, change_in=35 -> Qtr pulse (PULSE_W cycles), gap, D pulse; done 1 cycle; remaining 35->10->0.
//  start, change_in=15 -> D then N; change_in=20 -> D, D; change_in=5 -> a single N; busy spans each payout.
//  start, change_in=0 -> done at edge k+1, no eject pulses; change_in=7 or 40 -> err 1 cycle, no pulses.
//  start during an active payout of 35 -> ignored; the payout still ends with exactly Qtr+D.
//  clr low during the first Qtr pulse -> Qtr falls without waiting for clk.
//   All outputs are 0 and the block accepts a new start after clr is released.
//  DISP_LOW_COIN_EN, qtr_empty=1, change_in=30 -> D, D, D.
//   Same with nickel_empty=dime_empty=1, change_in=10 -> err, remaining=10.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin payout sequencer driving nickel/dime/quarter eject solenoids
//  clk        in   system clock, rising edge
//  clr        in   asynchronous active-low reset
//  start      in   one-cycle payout request, ignored while busy
//  change_in  in   change to pay in cents (multiple of 5, <= MAX_CHANGE)
//  N/D/Qtr    out  one-coin eject pulses (5c/10c/25c), PULSE_W cycles high, GAP_W cycles apart
//  busy       out  payout in progress (SELECT through DONE/ERR)
//  done/err   out  one-cycle completion / rejection pulses
//  remaining  out  cents still owed
//  Define DISP_LOW_COIN_EN to add nickel_empty/dime_empty/qtr_empty tube sensor inputs.
module change_dispenser #(
  parameter int MAX_CHANGE = 35,
  parameter int PULSE_W = 4,
  parameter int GAP_W = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [5:0] change_in,
`ifdef DISP_LOW_COIN_EN
  input  logic       nickel_empty,
  input  logic       dime_empty,
  input  logic       qtr_empty,
`endif
  output logic       N,
  output logic       D,
  output logic       Qtr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [5:0] remaining
);
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE, S_ERR} state_t;
  state_t     state;
  logic [7:0] cnt;
  logic [5:0] coin_val;
  logic       q_ok, d_ok, n_ok, pick_q, pick_d, pick_n, bad_req;
`ifdef DISP_LOW_COIN_EN
  assign q_ok = !qtr_empty;
  assign d_ok = !dime_empty;
  assign n_ok = !nickel_empty;
`else
  assign q_ok = 1'b1;
  assign d_ok = 1'b1;
  assign n_ok = 1'b1;
`endif
  // remaining is always a nonzero multiple of 5 here, so a nickel always fits
  assign pick_q  = remaining >= 6'd25 && q_ok;
  assign pick_d  = !pick_q && remaining >= 6'd10 && d_ok;
  assign pick_n  = !pick_q && !pick_d && n_ok;
  assign bad_req = (change_in % 6'd5) != 6'd0 || change_in > 6'(MAX_CHANGE);
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state     <= S_IDLE;
      {N, D, Qtr, busy, done, err} <= '0;
      remaining <= '0;
      cnt       <= '0;
      coin_val  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            busy <= 1'b1;
            if (change_in == 6'd0) begin
              remaining <= '0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else if (bad_req) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              remaining <= change_in;
              state     <= S_SELECT;
            end
          end
        S_SELECT:
          if (remaining == 6'd0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (pick_q || pick_d || pick_n) begin
            Qtr      <= pick_q;
            D        <= pick_d;
            N        <= pick_n;
            coin_val <= pick_q ? 6'd25 : pick_d ? 6'd10 : 6'd5;
            cnt      <= 8'(PULSE_W - 1);
            state    <= S_PULSE;
          end else begin
            err   <= 1'b1;
            state <= S_ERR;
          end
        S_PULSE:
          if (cnt == 8'd0) begin
            {N, D, Qtr} <= '0;
            remaining   <= remaining - coin_val;
            cnt         <= 8'(GAP_W - 1);
            state       <= S_GAP;
          end else cnt <= cnt - 8'd1;
        S_GAP:
          if (cnt == 8'd0) state <= S_SELECT;
          else cnt <= cnt - 8'd1;
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table, hand-written and random checks of change_dispenser against a coin-list model
module tb_change_dispenser;
  localparam int P = 4, G = 2, MAXC = 35;
  logic clk = 0, clr = 0, start = 0;
  logic [5:0] change_in = '0;
  logic qe = 0, de = 0, ne = 0;
  logic n, d, q, busy, done, err;
  logic [5:0] remaining;
  int checks = 0, errors = 0, model_rem = 0;
  int hi_q, hi_d, hi_n;
  bit saw_done, saw_err;
  typedef struct packed {logic n, d, q, busy, done, err; logic [5:0] rem;} obs_t;
  typedef struct {int c; int nq, nd, nn; bit dn, er;} vec_t;
  obs_t exp_q[$];
  vec_t tbl[$];
  change_dispenser #(.MAX_CHANGE(MAXC), .PULSE_W(P), .GAP_W(G)) dut (
    .clk(clk), .clr(clr), .start(start), .change_in(change_in),
`ifdef DISP_LOW_COIN_EN
    .nickel_empty(ne), .dime_empty(de), .qtr_empty(qe),
`endif
    .N(n), .D(d), .Qtr(q), .busy(busy), .done(done), .err(err), .remaining(remaining));
  always #5 clk = ~clk;
  function automatic obs_t mk(bit n_, bit d_, bit q_, bit b_, bit dn_, bit e_, int r);
    obs_t o;
    o.n = n_; o.d = d_; o.q = q_; o.busy = b_; o.done = dn_; o.err = e_; o.rem = 6'(r);
    return o;
  endfunction
  function automatic obs_t obs();
    return mk(n, d, q, busy, done, err, int'(remaining));
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Expected per-cycle trace after the accepting edge: greedy coin list from plain arithmetic
  task automatic build(input int c);
    int owed, coin;
    exp_q.delete();
    if (c == 0) begin
      model_rem = 0;
      exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
      return;
    end
    if (c % 5 != 0 || c > MAXC) begin
      exp_q.push_back(mk(0, 0, 0, 1, 0, 1, model_rem));
      return;
    end
    owed = c;
    while (1) begin
      exp_q.push_back(mk(0, 0, 0, 1, 0, 0, owed));
      if (owed == 0) begin
        exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        model_rem = 0;
        return;
      end
      coin = (owed >= 25 && !qe) ? 25 : (owed >= 10 && !de) ? 10 : !ne ? 5 : 0;
      if (coin == 0) begin
        exp_q.push_back(mk(0, 0, 0, 1, 0, 1, owed));
        model_rem = owed;
        return;
      end
      repeat (P) exp_q.push_back(mk(coin == 5, coin == 10, coin == 25, 1, 0, 0, owed));
      owed -= coin;
      repeat (G) exp_q.push_back(mk(0, 0, 0, 1, 0, 0, owed));
    end
  endtask
  // Called right after a negedge; noisy keeps hammering start (including on the DONE/ERR cycle)
  task automatic run(input int c, input bit noisy);
    build(c);
    hi_q = 0; hi_d = 0; hi_n = 0; saw_done = 0; saw_err = 0;
    start = 1; change_in = 6'(c);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("c=%0d cyc%0d", c, i), 32'(obs()), 32'(exp_q[i]));
      hi_q += int'(q); hi_d += int'(d); hi_n += int'(n);
      saw_done |= done; saw_err |= err;
      start = noisy;
      if (noisy) change_in = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    check($sformatf("c=%0d idle", c), 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, model_rem)));
    start = 0;
  endtask
  initial begin
    tbl.push_back('{35, 1, 1, 0, 1, 0});
    tbl.push_back('{15, 0, 1, 1, 1, 0});
    tbl.push_back('{20, 0, 2, 0, 1, 0});
    tbl.push_back('{5, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0});
    tbl.push_back('{7, 0, 0, 0, 0, 1});
    tbl.push_back('{40, 0, 0, 0, 0, 1});
    tbl.push_back('{30, 1, 0, 1, 1, 0});
    tbl.push_back('{25, 1, 0, 0, 1, 0});
    tbl.push_back('{10, 0, 1, 0, 1, 0});
    repeat (2) @(negedge clk);
    check("reset", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
    clr = 1;
    @(negedge clk);
    foreach (tbl[i]) begin
      run(tbl[i].c, 0);
      check($sformatf("coins c=%0d", tbl[i].c),
            hi_q / P * 10000 + hi_d / P * 1000 + hi_n / P * 100 + int'(saw_done) * 10 + int'(saw_err),
            tbl[i].nq * 10000 + tbl[i].nd * 1000 + tbl[i].nn * 100 + int'(tbl[i].dn) * 10 + int'(tbl[i].er));
    end
    run(35, 1);
    check("busy start ignored", hi_q * 100 + hi_d * 10 + hi_n, P * 100 + P * 10);
    start = 1; change_in = 6'd35;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("qtr before clr", 32'(q), 32'(1));
    #2 clr = 0;
    #1 check("qtr async drop", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    check("held reset", 32'(obs()), 32'(mk(0, 0, 0, 0, 0, 0, 0)));
    clr = 1; model_rem = 0;
    run(15, 0);
    check("after reset D+N", hi_d * 10 + hi_n, P * 10 + P);
    repeat (40) run($urandom_range(0, 63), $urandom_range(0, 3) == 0);
`ifdef DISP_LOW_COIN_EN
    qe = 1;
    run(30, 0);
    check("qtr empty 30", hi_q * 100 + hi_d * 10 + hi_n, 3 * P * 10);
    qe = 0; ne = 1; de = 1;
    run(10, 0);
    check("no coin err", int'(saw_err) * 10 + int'(remaining), 10 + 10);
    ne = 0; de = 0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
